// File: rtl/rr_bus_pkg.sv
// Shared types and helpers for the round-robin packet bus multiplexer.
package rr_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rr_state_e;

  // Widest requester vector the helpers below can handle.
  localparam int unsigned RR_MAX_W = 64;

  // Binary index of the single set bit of a one-hot vector (0 when empty).
  function automatic int unsigned onehot2idx(input logic [RR_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < RR_MAX_W; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Rotate the low n bits of v left by one position; bits at and above n come back zero.
  function automatic logic [RR_MAX_W-1:0] rotl1(input logic [RR_MAX_W-1:0] v,
                                               input int unsigned         n);
    logic [RR_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_W; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_bus_mux_pick.sv
// Round-robin picker: first set request at or above the one-hot pointer, wrapping around.
module rr_pick #(
  parameter int ARB_WIDTH = 4
) (
  input  logic [ARB_WIDTH-1:0] req,
  input  logic [ARB_WIDTH-1:0] ptr,
  output logic [ARB_WIDTH-1:0] gnt
);

  logic [2*ARB_WIDTH-1:0] dbl;
  logic [2*ARB_WIDTH-1:0] masked;

  // Doubling the request vector turns the wrap-around search into a plain upward search;
  // subtracting ptr clears the lowest request at/above ptr, and the mask isolates it.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ~(dbl - {{ARB_WIDTH{1'b0}}, ptr});
    gnt    = masked[ARB_WIDTH-1:0] | masked[2*ARB_WIDTH-1:ARB_WIDTH];
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-to-1 packet bus multiplexer: round-robin arbitration, grant held for a whole packet,
// zero-latency forwarding of the selected requester's beat.
module rr_bus_mux
  import rr_bus_pkg::*;
#(
  parameter  int ARB_WIDTH = 4,
  parameter  int DATA_W    = 32,
  localparam int SRC_W     = (ARB_WIDTH > 1) ? $clog2(ARB_WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic [ARB_WIDTH-1:0]        s_valid,
  input  logic [ARB_WIDTH-1:0]        s_last,
  input  logic [ARB_WIDTH*DATA_W-1:0] s_data,
  output logic [ARB_WIDTH-1:0]        s_ready,
  output logic                        m_valid,
  output logic                        m_last,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_ready,
  output logic [SRC_W-1:0]            m_src,
  output logic                        busy
);

  rr_state_e              state_q, state_d;
  logic [ARB_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ARB_WIDTH-1:0]   owner_q, owner_d;
  logic [SRC_W-1:0]       src_q, src_d;

  logic [ARB_WIDTH-1:0]   req;
  logic [ARB_WIDTH-1:0]   win;
  logic [ARB_WIDTH-1:0]   sel;
  logic [DATA_W-1:0]      mux_data;
  logic                   mux_last;
  logic                   fwd;
  logic                   accept;
  logic [SRC_W-1:0]       sel_idx;

  // A paused arbiter sees no requests, so nothing new can start.
  always_comb begin
    req = pause ? '0 : s_valid;
  end

  rr_pick #(
    .ARB_WIDTH (ARB_WIDTH)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (win)
  );

  // Source selection, AND-OR data mux and handshake steering toward the selected requester.
  always_comb begin
    sel      = (state_q == LOCKED) ? owner_q : win;
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < ARB_WIDTH; i++) begin
      if (sel[i]) begin
        mux_data = mux_data | s_data[i*DATA_W +: DATA_W];
        mux_last = mux_last | s_last[i];
      end
    end
    fwd     = ~rst & (|(sel & s_valid));
    accept  = fwd & m_ready;
    sel_idx = SRC_W'(onehot2idx(RR_MAX_W'(sel)));

    m_valid = fwd;
    m_data  = fwd ? mux_data : '0;
    m_last  = fwd & mux_last;
    s_ready = sel & {ARB_WIDTH{accept}};
    m_src   = rst ? '0 : (fwd ? sel_idx : src_q);
    busy    = ~rst & (state_q == LOCKED);
  end

  // Next-state logic: lock on a multi-beat packet start, release and rotate priority on its last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    src_d   = fwd ? sel_idx : src_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mux_last) begin
            ptr_d = ARB_WIDTH'(rotl1(RR_MAX_W'(win), ARB_WIDTH));
          end else begin
            owner_d = win;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && mux_last) begin
          state_d = IDLE;
          ptr_d   = ARB_WIDTH'(rotl1(RR_MAX_W'(owner_q), ARB_WIDTH));
          owner_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, priority pointer, packet owner and last-forwarded source registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= ARB_WIDTH'(1);
      owner_q <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed and random-scoreboard bench for rr_bus_mux (4 requesters, 32-bit payload).
module tb_rr_bus_mux;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            pause;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_last;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic            m_last;
  logic [DW-1:0]   m_data;
  logic            m_ready;
  logic [1:0]      m_src;
  logic            busy;

  int tests = 0;
  int fails = 0;

  // Random-phase generator and scoreboard state.
  int unsigned g_pkt [N];
  int unsigned g_beat[N];
  int unsigned g_len [N];
  bit          g_v   [N];
  int unsigned e_pkt [N];
  int unsigned e_beat[N];
  int unsigned served[N];
  int          lock_src;
  logic [N-1:0] acc;

  always #5 clk = ~clk;

  rr_bus_mux #(
    .ARB_WIDTH (N),
    .DATA_W    (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pause   (pause),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_ready (m_ready),
    .m_src   (m_src),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    s_valid[i]          = v;
    s_last[i]           = l;
    s_data[i*DW +: DW]  = d;
  endtask

  task automatic clr_all();
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
  endtask

  // Move to the drive point of the next cycle (1 time unit after the rising edge).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; m_ready = 1'b1;
    clr_all();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 32'hA0 + i);

    // Reset state with every requester valid.
    cyc(); #4;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_m_last",  m_last,  0);
    chk("rst_m_src",   m_src,   0);
    cyc(); cyc();
    rst = 1'b0;

    // 1: all valid single-beat packets rotate 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      #4;
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_src",   m_src,   k % 4);
      chk("t1_m_data",  m_data,  32'hA0 + (k % 4));
      chk("t1_s_ready", s_ready, 4'b0001 << (k % 4));
      cyc();
    end

    // 2: req0 3-beat packet holds the grant against req1.
    clr_all();
    set_src(0, 1'b1, 1'b0, 32'h100); set_src(1, 1'b1, 1'b1, 32'h200);
    #4;
    chk("t2_b0_src",    m_src,   0);
    chk("t2_b0_last",   m_last,  0);
    chk("t2_b0_busy",   busy,    0);
    chk("t2_b0_sready", s_ready, 4'b0001);
    cyc();
    set_src(0, 1'b1, 1'b0, 32'h101);
    #4;
    chk("t2_b1_src",    m_src,   0);
    chk("t2_b1_busy",   busy,    1);
    chk("t2_b1_data",   m_data,  32'h101);
    chk("t2_b1_sready", s_ready, 4'b0001);
    cyc();
    set_src(0, 1'b1, 1'b1, 32'h102);
    #4;
    chk("t2_b2_last",   m_last,  1);
    chk("t2_b2_data",   m_data,  32'h102);
    chk("t2_b2_sready", s_ready, 4'b0001);
    cyc();
    set_src(0, 1'b0, 1'b0, 32'h0);
    #4;
    chk("t2_r1_src",    m_src,   1);
    chk("t2_r1_data",   m_data,  32'h200);
    chk("t2_r1_busy",   busy,    0);
    chk("t2_r1_sready", s_ready, 4'b0010);
    cyc();
    set_src(1, 1'b0, 1'b0, 32'h0);

    // 3: backpressure mid-packet from req2 while req1 waits.
    set_src(2, 1'b1, 1'b0, 32'h300);
    #4;
    chk("t3_start_src",    m_src,   2);
    chk("t3_start_sready", s_ready, 4'b0100);
    cyc();
    set_src(2, 1'b1, 1'b0, 32'h301); set_src(1, 1'b1, 1'b1, 32'h210);
    m_ready = 1'b0;
    repeat (5) begin
      #4;
      chk("t3_bp_valid",  m_valid, 1);
      chk("t3_bp_data",   m_data,  32'h301);
      chk("t3_bp_sready", s_ready, 0);
      chk("t3_bp_busy",   busy,    1);
      chk("t3_bp_src",    m_src,   2);
      cyc();
    end
    m_ready = 1'b1;
    #4;
    chk("t3_rel_sready", s_ready, 4'b0100);
    chk("t3_rel_data",   m_data,  32'h301);
    cyc();
    set_src(2, 1'b1, 1'b1, 32'h302);
    #4;
    chk("t3_end_last", m_last, 1);
    chk("t3_end_src",  m_src,  2);
    cyc();
    set_src(2, 1'b0, 1'b0, 32'h0);
    #4;
    chk("t3_next_src",    m_src,   1);
    chk("t3_next_data",   m_data,  32'h210);
    chk("t3_next_sready", s_ready, 4'b0010);
    cyc();
    set_src(1, 1'b0, 1'b0, 32'h0);

    // 4a: pause in IDLE blocks req2 until it drops; m_src holds the last source.
    pause = 1'b1;
    set_src(2, 1'b1, 1'b1, 32'h400);
    repeat (3) begin
      #4;
      chk("t4_pause_valid",  m_valid, 0);
      chk("t4_pause_sready", s_ready, 0);
      chk("t4_pause_data",   m_data,  0);
      chk("t4_pause_src",    m_src,   1);
      cyc();
    end
    pause = 1'b0;
    #4;
    chk("t4_go_valid", m_valid, 1);
    chk("t4_go_src",   m_src,   2);
    chk("t4_go_data",  m_data,  32'h400);
    cyc();
    // 4b: pause raised in LOCKED lets req3's packet finish, then blocks req0.
    set_src(2, 1'b0, 1'b0, 32'h0);
    set_src(3, 1'b1, 1'b0, 32'h500);
    #4;
    chk("t4_lk_src",  m_src, 3);
    chk("t4_lk_busy", busy,  0);
    cyc();
    pause = 1'b1;
    set_src(3, 1'b1, 1'b0, 32'h501);
    #4;
    chk("t4_lk_valid", m_valid, 1);
    chk("t4_lk_data",  m_data,  32'h501);
    chk("t4_lk_busy2", busy,    1);
    cyc();
    set_src(3, 1'b1, 1'b1, 32'h502);
    #4;
    chk("t4_lk_last",  m_last, 1);
    chk("t4_lk_data2", m_data, 32'h502);
    cyc();
    set_src(3, 1'b0, 1'b0, 32'h0);
    set_src(0, 1'b1, 1'b1, 32'h600);
    #4;
    chk("t4_after_valid", m_valid, 0);
    chk("t4_after_busy",  busy,    0);
    cyc();
    pause = 1'b0;
    #4;
    chk("t4_resume_src",  m_src,  0);
    chk("t4_resume_data", m_data, 32'h600);
    cyc();
    set_src(0, 1'b0, 1'b0, 32'h0);

    // 5: reset on the 2nd beat of req1's packet.
    set_src(1, 1'b1, 1'b0, 32'h700);
    #4;
    chk("t5_b0_src", m_src, 1);
    cyc();
    set_src(1, 1'b1, 1'b0, 32'h701);
    rst = 1'b1;
    #4;
    chk("t5_rst_valid",  m_valid, 0);
    chk("t5_rst_busy",   busy,    0);
    chk("t5_rst_sready", s_ready, 0);
    chk("t5_rst_src",    m_src,   0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 1'b1, 32'hA0 + i);
    #4;
    chk("t5_post_busy", busy,   0);
    chk("t5_post_src",  m_src,  0);
    chk("t5_post_data", m_data, 32'hA0);
    cyc();
    #4;
    chk("t5_post_src2", m_src, 1);
    cyc();
    clr_all();

    // 6: lone requesters, including wrap-around from the top of the pointer.
    set_src(2, 1'b1, 1'b1, 32'h800);
    #4; chk("t6_r2", m_src, 2); cyc();
    set_src(2, 1'b0, 1'b0, 32'h0); set_src(0, 1'b1, 1'b1, 32'h801);
    #4; chk("t6_wrap_r0", m_src, 0); cyc();
    set_src(0, 1'b0, 1'b0, 32'h0); set_src(3, 1'b1, 1'b1, 32'h802);
    #4; chk("t6_r3", m_src, 3); cyc();
    set_src(3, 1'b0, 1'b0, 32'h0); set_src(0, 1'b1, 1'b1, 32'h803);
    #4; chk("t6_r0", m_src, 0); chk("t6_r0_data", m_data, 32'h803); cyc();
    clr_all();

    // Random traffic: per-source packet order, payload integrity, no torn packets.
    for (int i = 0; i < N; i++) begin
      g_pkt[i] = 0; g_beat[i] = 0; g_len[i] = $urandom_range(1, 4); g_v[i] = 1'b0;
      e_pkt[i] = 0; e_beat[i] = 0; served[i] = 0;
    end
    lock_src = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!g_v[i] && $urandom_range(0, 2) == 0) g_v[i] = 1'b1;
        set_src(i, g_v[i], (g_beat[i] == g_len[i] - 1),
                {4'(i), 12'(g_pkt[i]), 16'(g_beat[i])});
      end
      m_ready = ($urandom_range(0, 9) < 7);
      pause   = ($urandom_range(0, 9) == 0);
      #4;
      acc = s_ready & s_valid;
      if (m_valid) chk("rnd_sready_other", s_ready & ~(4'b0001 << m_src), 0);
      else         chk("rnd_sready_idle",  s_ready, 0);
      if (m_valid && m_ready) begin
        int s;
        s = int'(m_src);
        chk("rnd_payload", m_data, {4'(s), 12'(e_pkt[s]), 16'(e_beat[s])});
        chk("rnd_last",    m_last, (e_beat[s] == g_len[s] - 1));
        if (lock_src >= 0) chk("rnd_torn", m_src, lock_src);
        lock_src = m_last ? -1 : s;
        served[s]++;
        if (m_last) begin e_pkt[s]++; e_beat[s] = 0; end
        else        e_beat[s]++;
      end
      cyc();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          g_v[i] = 1'b0;
          if (g_beat[i] == g_len[i] - 1) begin
            g_pkt[i]++; g_beat[i] = 0; g_len[i] = $urandom_range(1, 4);
          end else begin
            g_beat[i]++;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) chk("rnd_served", (served[i] != 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
